// File: rtl/case_property_responder.sv
// case_property_responder: device-side responder for req/ack and valid/ready handshakes.
// The opcode selects the response timing and is captured when a transaction starts.
// Latency: 0 cycles for opcodes 000/001. For opcodes 010/011/100 the response arrives
// N cycles after the trigger, where N is the clamped delay.
// Backpressure: none. Triggers are dropped while a response is pending and in the response cycle.
// Build option: CASE_RESP_ERR_STICKY_EN makes error hold high until reset.
//   Without it, error is a one-cycle pulse for each abort.
// Ports:
//   clk, rst_n  clock and async active-low reset (release is synchronised internally)
//   opcode      protocol mode select, sampled in IDLE only
//   delay_cfg   requested delay for opcodes 011/100, sampled with opcode
//   req, valid  trigger strobes
//   ack, ready  response strobes
//   busy        registered, high while a delayed response is pending
//   error       valid dropped while waiting on an opcode 100 transaction
module case_property_responder #(
    parameter int MAX_DELAY = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic [3:0] delay_cfg,
    input  logic       req,
    input  logic       valid,
    output logic       ack,
    output logic       ready,
    output logic       busy,
    output logic       error
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] MAX_D = 4'(MAX_DELAY);

    // Reset asserts asynchronously and releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [2:0] op_q, op_nxt;
    logic [3:0] cfg_lo1, n_short, n_long, load_n;
    logic       load_en, ack_c, ready_c, abort;
    logic       busy_q, error_q;

    // Clamp the delay before loading it, so the 4-bit counter can never wrap.
    assign cfg_lo1 = (delay_cfg == 4'd0) ? 4'd1 : delay_cfg;
    assign n_short = (cfg_lo1 > 4'd3) ? 4'd3 : cfg_lo1;
    assign n_long  = (cfg_lo1 > MAX_D) ? MAX_D : cfg_lo1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        ack_c     = 1'b0;
        ready_c   = 1'b0;
        abort     = 1'b0;
        load_en   = 1'b0;
        load_n    = 4'd0;
        case (state)
            IDLE: begin
                case (opcode)
                    3'b000: ack_c = req;
                    3'b001: ready_c = valid;
                    3'b010: begin
                        load_en = req;
                        load_n  = 4'd2;
                    end
                    3'b011: begin
                        load_en = req;
                        load_n  = n_short;
                    end
                    3'b100: begin
                        load_en = valid;
                        load_n  = n_long;
                    end
                    default: begin
                    end
                endcase
                // A delay of 1 responds in the next cycle, so the wait phase is skipped.
                if (load_en) begin
                    op_nxt    = opcode;
                    cnt_nxt   = load_n;
                    state_nxt = (load_n == 4'd1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (op_q == 3'b100 && !valid) begin
                    abort     = 1'b1;
                    cnt_nxt   = 4'd0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt <= 4'd2) begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                ack_c     = (op_q != 3'b100);
                ready_c   = (op_q == 3'b100);
                cnt_nxt   = 4'd0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            op_q    <= 3'd0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            op_q    <= op_nxt;
            busy_q  <= (state_nxt != IDLE);
`ifdef CASE_RESP_ERR_STICKY_EN
            error_q <= error_q | abort;
`else
            error_q <= abort;
`endif
        end
    end

    // The pass-through paths must also be silenced while reset is held.
    assign ack   = ack_c & rst_int_n;
    assign ready = ready_c & rst_int_n;
    assign busy  = busy_q;
    assign error = error_q;

endmodule

// File: tb/tb_case_property_responder.sv
`timescale 1ns/1ps
module tb_case_property_responder;
    localparam int MAXD = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic [3:0] delay_cfg = 4'd0;
    logic       req = 1'b0;
    logic       valid = 1'b0;
    logic       ack, ready, busy, error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    case_property_responder #(.MAX_DELAY(MAXD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .delay_cfg(delay_cfg),
        .req      (req),
        .valid    (valid),
        .ack      (ack),
        .ready    (ready),
        .busy     (busy),
        .error    (error)
    );

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %b, expected %b", nm, $time, act, exp);
        end
    endtask

    // Reference model. It tracks one pending response by the cycle number in which
    // that response must appear.
    int cyc_n  = 0;
    int rel    = 0;
    int resp_c = 0;
    bit pend = 1'b0, kind_rdy = 1'b0, err_m = 1'b0, act_pre = 1'b0, ab = 1'b0;

    function automatic int clampi(input int v, input int hi);
        int r;
        r = (v < 1) ? 1 : v;
        return (r > hi) ? hi : r;
    endfunction

    always @(posedge clk) begin
        act_pre = rst_n && (rel >= 2);
        if (!act_pre) begin
            pend  = 1'b0;
            err_m = 1'b0;
        end else begin
            ab = pend && kind_rdy && (cyc_n < resp_c) && !valid;
`ifdef CASE_RESP_ERR_STICKY_EN
            err_m = err_m || ab;
`else
            err_m = ab;
`endif
            if (pend) begin
                if (ab || cyc_n == resp_c) pend = 1'b0;
            end else if (opcode == 3'd2 && req) begin
                pend = 1'b1; kind_rdy = 1'b0; resp_c = cyc_n + 2;
            end else if (opcode == 3'd3 && req) begin
                pend = 1'b1; kind_rdy = 1'b0; resp_c = cyc_n + clampi(int'(delay_cfg), 3);
            end else if (opcode == 3'd4 && valid) begin
                pend = 1'b1; kind_rdy = 1'b1; resp_c = cyc_n + clampi(int'(delay_cfg), MAXD);
            end
        end
        rel = !rst_n ? 0 : ((rel < 2) ? rel + 1 : 2);
        cyc_n++;
    end

    logic e_act, e_ack, e_rdy, e_busy, e_err;
    always @(negedge clk) begin
        e_act  = rst_n && (rel >= 2);
        e_ack  = e_act && (pend ? (cyc_n == resp_c && !kind_rdy) : (opcode == 3'd0 && req));
        e_rdy  = e_act && (pend ? (cyc_n == resp_c && kind_rdy) : (opcode == 3'd1 && valid));
        e_busy = e_act && pend;
        e_err  = e_act && err_m;
        chk("model_ack", ack, e_ack);
        chk("model_ready", ready, e_rdy);
        chk("model_busy", busy, e_busy);
        chk("model_error", error, e_err);
    end

    // Drive the inputs for one cycle just after the rising edge, then return at mid-cycle
    // so the caller can check that cycle's outputs.
    task automatic drv(input logic [2:0] op, input logic [3:0] cfg, input logic r, input logic v);
        @(posedge clk);
        #1;
        opcode = op; delay_cfg = cfg; req = r; valid = v;
        @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ack"}, ack, 1'b0);
        chk({nm, "_ready"}, ready, 1'b0);
        chk({nm, "_busy"}, busy, 1'b0);
        chk({nm, "_error"}, error, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic       sticky_exp;
        logic [2:0] rop;
        logic [3:0] rcfg;
        logic       rr, rv;
`ifdef CASE_RESP_ERR_STICKY_EN
        sticky_exp = 1'b1;
`else
        sticky_exp = 1'b0;
`endif
        rop = 3'd0;

        // Reset state
        @(negedge clk);
        chk_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("post_reset");

        // Opcode 000: combinational ack for three cycles
        drv(3'd0, 4'd0, 1'b0, 1'b0);
        chk("op0_idle_ack", ack, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drv(3'd0, 4'd0, 1'b1, 1'b0);
            chk("op0_ack", ack, 1'b1);
            chk("op0_busy", busy, 1'b0);
        end
        drv(3'd0, 4'd0, 1'b0, 1'b0);
        chk("op0_ack_off", ack, 1'b0);

        // Opcode 010: response at t+2; a second req is dropped
        drv(3'd2, 4'd0, 1'b1, 1'b0);
        chk("op2_t0_ack", ack, 1'b0);
        chk("op2_t0_busy", busy, 1'b0);
        drv(3'd2, 4'd0, 1'b1, 1'b0);
        chk("op2_t1_ack", ack, 1'b0);
        chk("op2_t1_busy", busy, 1'b1);
        drv(3'd2, 4'd0, 1'b0, 1'b0);
        chk("op2_t2_ack", ack, 1'b1);
        chk("op2_t2_busy", busy, 1'b1);
        drv(3'd2, 4'd0, 1'b0, 1'b0);
        chk("op2_t3_ack", ack, 1'b0);
        chk("op2_t3_busy", busy, 1'b0);

        // Opcode 011: delay 7 is clamped to 3, and delay 0 is treated as 1
        drv(3'd3, 4'd7, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            drv(3'd3, 4'd7, 1'b0, 1'b0);
            chk("op3_d7_ack", ack, (k == 3) ? 1'b1 : 1'b0);
        end
        drv(3'd3, 4'd0, 1'b1, 1'b0);
        drv(3'd3, 4'd0, 1'b0, 1'b0);
        chk("op3_d0_ack", ack, 1'b1);
        chk("op3_d0_busy", busy, 1'b1);
        drv(3'd3, 4'd0, 1'b0, 1'b0);
        chk("op3_d0_after", ack, 1'b0);

        // Opcode 100: delay 12 is clamped to MAX_DELAY=10, with valid held high
        drv(3'd4, 4'd12, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            drv(3'd4, 4'd12, 1'b0, (k < 10) ? 1'b1 : 1'b0);
            chk("op4_ready", ready, (k == 10) ? 1'b1 : 1'b0);
            chk("op4_busy", busy, 1'b1);
        end
        drv(3'd4, 4'd12, 1'b0, 1'b0);
        chk("op4_done_ready", ready, 1'b0);
        chk("op4_done_busy", busy, 1'b0);

        // Opcode 100: valid drops in the fifth wait cycle, which aborts the transaction
        drv(3'd4, 4'd12, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            drv(3'd4, 4'd12, 1'b0, 1'b1);
            chk("abort_wait_ready", ready, 1'b0);
        end
        drv(3'd4, 4'd12, 1'b0, 1'b0);
        chk("abort_drop_error", error, 1'b0);
        chk("abort_drop_busy", busy, 1'b1);
        drv(3'd4, 4'd12, 1'b0, 1'b0);
        chk("abort_error", error, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", ready, 1'b0);
        drv(3'd4, 4'd12, 1'b0, 1'b0);
        chk("abort_error_next", error, sticky_exp);

        // Reset in the middle of a wait: outputs clear at once and no response follows
        drv(3'd4, 4'd5, 1'b0, 1'b1);
        drv(3'd4, 4'd5, 1'b0, 1'b1);
        chk("rstmid_busy1", busy, 1'b1);
        drv(3'd4, 4'd5, 1'b0, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk_zero("rstmid_assert");
        drv(3'd4, 4'd5, 1'b0, 1'b0);
        chk_zero("rstmid_hold");
        drv(3'd4, 4'd5, 1'b0, 1'b0);
        chk("rstmid_no_ready", ready, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        drv(3'd4, 4'd2, 1'b0, 1'b1);
        chk("rst_retrig_t0", ready, 1'b0);
        drv(3'd4, 4'd2, 1'b0, 1'b1);
        chk("rst_retrig_t1_busy", busy, 1'b1);
        drv(3'd4, 4'd2, 1'b0, 1'b0);
        chk("rst_retrig_ready", ready, 1'b1);
        drv(3'd4, 4'd2, 1'b0, 1'b0);

        // Opcode 111: no response of any kind
        for (int k = 0; k < 50; k++) begin
            drv(3'd7, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk_zero("op7");
        end

        // Random traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                @(posedge clk);
                #1 rst_n = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) rop = 3'($urandom_range(0, 7));
            rcfg = 4'($urandom_range(0, 15));
            rr   = ($urandom_range(0, 2) == 0);
            rv   = (rop == 3'd4) ? ($urandom_range(0, 11) != 0) : 1'($urandom_range(0, 1));
            drv(rop, rcfg, rr, rv);
        end

        drv(3'd0, 4'd0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/case_property_responder.md
# case_property_responder

Opcode-selected handshake responder that drives the far end of the req/ack and valid/ready protocols whose per-opcode rules are checked by the case-property assertion suite. Given an incoming `req` or `valid`, it produces `ack` or `ready` with the timing mandated for the opcode latched at trigger time. It sits as the device-side model in SVA regression benches, so checker modules can be exercised against a known-compliant (and, via `delay_cfg`, stressed) counterpart.

## Interface
- `MAX_DELAY`, default 10: upper clamp for opcode 3'b100 response delay; legal range 3..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  3  protocol mode select; sampled only in IDLE.
- `delay_cfg`  in  4  requested response delay in cycles for opcodes 3'b011/3'b100; sampled with opcode.
- `req`  in  1  request strobe.
- `valid`  in  1  data-valid strobe.
- `ack`  out  1  request acknowledge.
- `ready`  out  1  valid acknowledge.
- `busy`  out  1  high while a delayed response is pending.
- `error`  out  1  protocol violation seen (valid dropped mid-wait).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE, per current `opcode`:
  - 3'b000: `ack` = `req`, combinational, same cycle; stay IDLE.
  - 3'b001: `ready` = `valid`, combinational, same cycle; stay IDLE.
  - 3'b010: on `req`, latch opcode, load cnt=2, go WAIT.
  - 3'b011: on `req`, latch opcode, load cnt = clamp(`delay_cfg`, 1, 3), go WAIT.
  - 3'b100: on `valid`, latch opcode, load cnt = clamp(`delay_cfg`, 1, `MAX_DELAY`), go WAIT.
  - Other opcodes: no response; `ack`, `ready`, and `error` stay 0.
- WAIT: decrement cnt each cycle. When cnt reaches 1, go RESP. The `opcode` and `delay_cfg` inputs are ignored. A new `req` is dropped (not queued).
- WAIT with latched 3'b100: `valid` is sampled every WAIT cycle and must stay high throughout. If `valid` is 0 in any WAIT cycle, abort to IDLE, assert `error`, and do not raise `ready`.
- RESP: pulse `ack` (3'b010/3'b011) or `ready` (3'b100) for exactly one cycle, then return to IDLE. A trigger in the same RESP cycle is ignored; the next trigger is accepted the following cycle.
- `delay_cfg` = 0 is treated as 1. The counter is 4 bits and never wraps, because clamping precedes the load.
- Simultaneous `req` and `valid` in IDLE: only the input relevant to the current opcode acts; the other is ignored.

## Timing
- Reset (async assert, sync-released internally):
  - outputs: `ack`=0, `ready`=0, `busy`=0, `error`=0.
  - internal: state=IDLE, cnt=0, latched opcode=0.
- Reset mid-WAIT or mid-RESP aborts the transaction with no response pulse.
- Latency for opcodes 3'b000/3'b001: 0 cycles.
- Latency for delayed opcodes, with trigger sampled at edge t:
  - `ack`/`ready` is high in cycle t+N, where N = loaded cnt.
  - 3'b010 gives exactly t+2, which satisfies `req |=> ##1 ack`.
- `busy`: registered; high from cycle t+1 through the RESP cycle inclusive.
- `error` on abort: high in the cycle after the `valid`-low sample.

## Configuration
- `CASE_RESP_ERR_STICKY_EN` defined: `error` is sticky and holds 1 until `rst_n` asserts.
- `CASE_RESP_ERR_STICKY_EN` undefined: `error` is a single-cycle pulse per abort.
- FSM behaviour is identical in both builds.

## Test plan
- opcode=3'b000, `req` high in cycles 3–5 -> `ack` high in exactly cycles 3–5; `busy` stays 0.
- opcode=3'b010, `req` pulse at cycle 4, then `req` again at cycle 5 -> single `ack` at cycle 6; the second `req` is dropped; `busy` high in cycles 5–6.
- opcode=3'b011, `delay_cfg`=7, `req` at cycle 2 -> clamped to 3, `ack` at cycle 5. Repeat with `delay_cfg`=0 -> `ack` at cycle 3.
- opcode=3'b100, `delay_cfg`=12, `MAX_DELAY`=10, `valid` held from cycle 1 -> `ready` at cycle 11. Repeat with `valid` dropped at cycle 6:
  - no `ready` pulse;
  - `error` at cycle 7: one-cycle pulse without the macro, held high with `CASE_RESP_ERR_STICKY_EN`.
- opcode=3'b100, `delay_cfg`=5, `valid` at cycle 0, `rst_n` low at cycle 3 -> all outputs 0 immediately; no `ready` at cycle 5; after release a new trigger is accepted normally.
- opcode=3'b111, `req`/`valid` toggling randomly for 50 cycles -> `ack`, `ready`, `busy`, `error` all stay 0.
